fifo_scoreboard: RTL and testbench

Synthesizable, parametrised in-order scoreboard that shadows any FIFO-like block. It records every accepted write, checks every read against the oldest outstanding write, and reports mismatch, overflow, underflow and (optionally) starvation. It is attached beside a FIFO through `bind`, for both formal runs and simulation, without needing a vendor scoreboard IP. It generalises the fixed 4-bit/4-deep checker to arbitrary width and depth, adds a data-compare mask, sticky error reporting with first-error capture, and a same-cycle bypass rule.

---
 rtl/fifo_sb_pkg.sv | 33 +++
 rtl/fifo_sb_queue.sv | 51 +++++
 rtl/fifo_scoreboard.sv | 149 ++++++++++++++
 tb/tb_fifo_scoreboard.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_sb_pkg.sv
// Shared types for the in-order FIFO scoreboard: error codes, checker state,
// and the helper that picks which error is reported first.
package fifo_sb_pkg;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_MISMATCH  = 3'd1,
    ERR_OVERFLOW  = 3'd2,
    ERR_UNDERFLOW = 3'd3,
    ERR_TIMEOUT   = 3'd4
  } err_code_t;

  typedef enum logic {
    SB_OK  = 1'b0,
    SB_ERR = 1'b1
  } state_t;

  // When several errors land in one cycle, the one reported is chosen in
  // the order underflow, overflow, mismatch, timeout.
  function automatic err_code_t pick_first_err(input logic underflow,
                                               input logic overflow,
                                               input logic mismatch,
                                               input logic timeout);
    err_code_t code;
    code = ERR_NONE;
    if (underflow)     code = ERR_UNDERFLOW;
    else if (overflow) code = ERR_OVERFLOW;
    else if (mismatch) code = ERR_MISMATCH;
    else if (timeout)  code = ERR_TIMEOUT;
    return code;
  endfunction

endpackage

// File: rtl/fifo_sb_queue.sv
// Shadow circular buffer for the scoreboard. Pointers wrap at DEPTH, which
// need not be a power of two. Push and pop in the same cycle are allowed
// even when full, since the slot being overwritten is the one being popped.
module fifo_sb_queue #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rstN,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          push_data,
  output logic [DATA_W-1:0]          head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pointers and occupancy; an asynchronous reset discards every entry.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= bump(wr_ptr);
      if (pop)  rd_ptr <= bump(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_scoreboard.sv
// In-order scoreboard that shadows a FIFO-like block: records accepted
// writes, checks each read against the oldest outstanding write under
// CMP_MASK, and latches sticky errors with first-error capture.
// Optional feature macro: FIFO_SB_TIMEOUT_EN enables starvation detection.
module fifo_scoreboard
  import fifo_sb_pkg::*;
#(
  parameter int                DATA_W      = 4,
  parameter int                MAX_PENDING = 4,
  parameter logic [DATA_W-1:0] CMP_MASK    = '1,
  parameter int                TIMEOUT     = 16
) (
  input  logic                             clk,
  input  logic                             rstN,
  input  logic                             in_vld,
  input  logic [DATA_W-1:0]                in_data,
  input  logic                             out_vld,
  input  logic [DATA_W-1:0]                out_data,
  output logic [$clog2(MAX_PENDING+1)-1:0] pending,
  output logic                             err_mismatch,
  output logic                             err_overflow,
  output logic                             err_underflow,
  output logic                             err_timeout,
  output logic                             err_any,
  output err_code_t                        first_err
);

  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  logic [DATA_W-1:0] head;
  logic [PEND_W-1:0] count;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              cmp_en;
  logic [DATA_W-1:0] cmp_ref;
  logic              mismatch_ev;
  logic              overflow_ev;
  logic              underflow_ev;
  logic              timeout_ev;
  logic              any_ev;
  state_t            state;
  state_t            state_next;
  err_code_t         first_err_next;

  fifo_sb_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_PENDING)
  ) u_queue (
    .clk       (clk),
    .rstN      (rstN),
    .push      (push),
    .pop       (pop),
    .push_data (in_data),
    .head      (head),
    .count     (count)
  );

  assign empty = (count == '0);
  assign full  = (count == PEND_W'(MAX_PENDING));

  // A write plus a read on an empty queue is a bypass and stores nothing;
  // on a non-empty queue the pop frees a slot, so the push is legal at full.
  assign push = in_vld & (out_vld ? ~empty : ~full);
  assign pop  = out_vld & ~empty;

  assign overflow_ev  = in_vld & ~out_vld & full;
  assign underflow_ev = out_vld & ~in_vld & empty;

  // The bypass compares the read directly against the write of that cycle.
  assign cmp_en      = out_vld & (in_vld | ~empty);
  assign cmp_ref     = empty ? in_data : head;
  assign mismatch_ev = cmp_en & (|((out_data ^ cmp_ref) & CMP_MASK));

`ifdef FIFO_SB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] starve_cnt;

  // Count cycles the oldest entry waits without a read; saturate at TIMEOUT.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      starve_cnt <= '0;
    end else if (pop || empty) begin
      starve_cnt <= '0;
    end else if (starve_cnt != TO_W'(TIMEOUT)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign timeout_ev = (starve_cnt == TO_W'(TIMEOUT));
`else
  assign timeout_ev = 1'b0;
`endif

  assign any_ev = mismatch_ev | overflow_ev | underflow_ev | timeout_ev;

  // Sticky error flags keep latching even after the first error.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      err_mismatch  <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
      err_timeout   <= 1'b0;
    end else begin
      if (mismatch_ev)  err_mismatch  <= 1'b1;
      if (overflow_ev)  err_overflow  <= 1'b1;
      if (underflow_ev) err_underflow <= 1'b1;
      if (timeout_ev)   err_timeout   <= 1'b1;
    end
  end

  // Checker state and first-error code registers.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state     <= SB_OK;
      first_err <= ERR_NONE;
    end else begin
      state     <= state_next;
      first_err <= first_err_next;
    end
  end

  // Leave SB_OK on the first error and freeze its code; only reset returns.
  always_comb begin
    state_next     = state;
    first_err_next = first_err;
    unique case (state)
      SB_OK: begin
        if (any_ev) begin
          state_next     = SB_ERR;
          first_err_next = pick_first_err(underflow_ev, overflow_ev,
                                          mismatch_ev, timeout_ev);
        end
      end
      SB_ERR: begin
        state_next = SB_ERR;
      end
      default: begin
        state_next = SB_OK;
      end
    endcase
  end

  assign pending = count;
  assign err_any = err_mismatch | err_overflow | err_underflow | err_timeout;

endmodule

// File: tb/tb_fifo_scoreboard.sv
// Bench for fifo_scoreboard: directed scenarios followed by random traffic,
// all checked against a queue-based reference model.
// Honours FIFO_SB_TIMEOUT_EN to decide whether starvation errors are expected.
module tb_fifo_scoreboard;
  import fifo_sb_pkg::*;

  localparam int             DATA_W      = 4;
  localparam int             MAX_PENDING = 4;
  localparam int             TIMEOUT     = 16;
  localparam logic [DATA_W-1:0] MASK     = 4'b0111;
`ifdef FIFO_SB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic              clk      = 1'b0;
  logic              rstN     = 1'b0;
  logic              in_vld   = 1'b0;
  logic [DATA_W-1:0] in_data  = '0;
  logic              out_vld  = 1'b0;
  logic [DATA_W-1:0] out_data = '0;
  logic [2:0]        pending;
  logic              err_mismatch;
  logic              err_overflow;
  logic              err_underflow;
  logic              err_timeout;
  logic              err_any;
  err_code_t         first_err;

  int evaluated = 0;
  int failures  = 0;

  logic [DATA_W-1:0] mq [$];
  bit                m_mis;
  bit                m_ovf;
  bit                m_unf;
  bit                m_to;
  logic [2:0]        m_first;
  int                m_run;

  fifo_scoreboard #(
    .DATA_W      (DATA_W),
    .MAX_PENDING (MAX_PENDING),
    .CMP_MASK    (MASK),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rstN          (rstN),
    .in_vld        (in_vld),
    .in_data       (in_data),
    .out_vld       (out_vld),
    .out_data      (out_data),
    .pending       (pending),
    .err_mismatch  (err_mismatch),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow),
    .err_timeout   (err_timeout),
    .err_any       (err_any),
    .first_err     (first_err)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    evaluated++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, "/pending"},   32'(pending),       32'(mq.size()));
    checkVal({tag, "/mismatch"},  32'(err_mismatch),  32'(m_mis));
    checkVal({tag, "/overflow"},  32'(err_overflow),  32'(m_ovf));
    checkVal({tag, "/underflow"}, 32'(err_underflow), 32'(m_unf));
    checkVal({tag, "/timeout"},   32'(err_timeout),   32'(m_to));
    checkVal({tag, "/err_any"},   32'(err_any),       32'(m_mis | m_ovf | m_unf | m_to));
    checkVal({tag, "/first_err"}, 32'(first_err),     32'(m_first));
  endtask

  // Reference model: one transaction per clock, written from the rules.
  task automatic modelStep(input bit iv, input logic [DATA_W-1:0] id,
                           input bit ov, input logic [DATA_W-1:0] od);
    bit u = 0, o = 0, m = 0, t = 0;
    logic [DATA_W-1:0] exp_head;
    if (TO_EN && m_run >= TIMEOUT) t = 1;
    if (mq.size() > 0 && !ov) m_run++;
    else m_run = 0;
    if (iv && ov) begin
      if (mq.size() == 0) exp_head = id;
      else begin
        exp_head = mq.pop_front();
        mq.push_back(id);
      end
      m = (((od ^ exp_head) & MASK) != 0);
    end else if (iv) begin
      if (mq.size() == MAX_PENDING) o = 1;
      else mq.push_back(id);
    end else if (ov) begin
      if (mq.size() == 0) u = 1;
      else begin
        exp_head = mq.pop_front();
        m = (((od ^ exp_head) & MASK) != 0);
      end
    end
    if (!(m_mis | m_ovf | m_unf | m_to) && (u | o | m | t))
      m_first = u ? 3'd3 : o ? 3'd2 : m ? 3'd1 : 3'd4;
    m_mis |= m;
    m_ovf |= o;
    m_unf |= u;
    m_to  |= t;
  endtask

  task automatic applyStimulus(input string tag, input bit iv, input logic [DATA_W-1:0] id,
                               input bit ov, input logic [DATA_W-1:0] od);
    @(negedge clk);
    in_vld   = iv;
    in_data  = id;
    out_vld  = ov;
    out_data = od;
    modelStep(iv, id, ov, od);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // Reset is asserted between clock edges and checked before the next edge.
  task automatic doReset(input string tag);
    @(negedge clk);
    rstN    = 1'b0;
    in_vld  = 1'b0;
    out_vld = 1'b0;
    mq.delete();
    m_mis = 0; m_ovf = 0; m_unf = 0; m_to = 0;
    m_first = 3'd0;
    m_run = 0;
    #1;
    checkOutput(tag);
    @(negedge clk);
    rstN = 1'b1;
  endtask

  initial begin
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] exp_head;
    bit                iv;
    bit                ov;
    int                r;

    $display("[TB] starting fifo_scoreboard bench (timeout feature %0d)", TO_EN);
    doReset("reset");

    // Push 1..4 then pop them back in order.
    for (int i = 1; i <= 4; i++) applyStimulus("fill", 1'b1, DATA_W'(i), 1'b0, '0);
    checkVal("fill/pending4", 32'(pending), 32'd4);
    for (int i = 1; i <= 4; i++) applyStimulus("drain", 1'b0, '0, 1'b1, DATA_W'(i));
    checkVal("drain/pending0", 32'(pending), 32'd0);
    checkVal("drain/first_err", 32'(first_err), 32'd0);

    // Fifth push into a full queue is an overflow.
    doReset("reset_ovf");
    for (int i = 1; i <= 5; i++) applyStimulus("ovf", 1'b1, DATA_W'(i), 1'b0, '0);
    checkVal("ovf/flag", 32'(err_overflow), 32'd1);
    checkVal("ovf/first_err", 32'(first_err), 32'd2);
    checkVal("ovf/pending", 32'(pending), 32'd4);

    // Bypass on an empty queue, matching then mismatching.
    doReset("reset_byp");
    applyStimulus("byp_ok", 1'b1, 4'hA, 1'b1, 4'hA);
    checkVal("byp_ok/err_any", 32'(err_any), 32'd0);
    checkVal("byp_ok/pending", 32'(pending), 32'd0);
    applyStimulus("byp_bad", 1'b1, 4'hA, 1'b1, 4'hB);
    checkVal("byp_bad/mismatch", 32'(err_mismatch), 32'd1);

    // Simultaneous push/pop at full, then drain with 9 last.
    doReset("reset_full");
    for (int i = 1; i <= 4; i++) applyStimulus("full_fill", 1'b1, DATA_W'(i), 1'b0, '0);
    applyStimulus("full_swap", 1'b1, 4'h9, 1'b1, 4'h1);
    checkVal("full_swap/overflow", 32'(err_overflow), 32'd0);
    applyStimulus("full_drain", 1'b0, '0, 1'b1, 4'h2);
    applyStimulus("full_drain", 1'b0, '0, 1'b1, 4'h3);
    applyStimulus("full_drain", 1'b0, '0, 1'b1, 4'h4);
    applyStimulus("full_drain", 1'b0, '0, 1'b1, 4'h9);
    checkVal("full_drain/err_any", 32'(err_any), 32'd0);

    // Read from an empty queue.
    doReset("reset_unf");
    applyStimulus("unf", 1'b0, '0, 1'b1, 4'h5);
    checkVal("unf/first_err", 32'(first_err), 32'd3);
    checkVal("unf/err_any", 32'(err_any), 32'd1);
    applyStimulus("unf_then_mis", 1'b1, 4'h2, 1'b1, 4'h6);
    checkVal("unf_then_mis/first_err", 32'(first_err), 32'd3);

    // One entry left waiting with no reads.
    doReset("reset_to");
    applyStimulus("to_push", 1'b1, 4'h7, 1'b0, '0);
    for (int i = 0; i < TIMEOUT; i++) applyStimulus("to_wait", 1'b0, '0, 1'b0, '0);
    checkVal("to_wait/not_yet", 32'(err_timeout), 32'd0);
    applyStimulus("to_fire", 1'b0, '0, 1'b0, '0);
    checkVal("to_fire/flag", 32'(err_timeout), 32'(TO_EN));
    applyStimulus("to_push2", 1'b1, 4'h3, 1'b0, '0);
    doReset("mid_reset");
    checkVal("mid_reset/err_any", 32'(err_any), 32'd0);

    // Random traffic in several segments, each starting from reset.
    for (int seg = 0; seg < 6; seg++) begin
      doReset("reset_rand");
      for (int n = 0; n < 80; n++) begin
        iv = ($urandom_range(0, 99) < 50);
        ov = ($urandom_range(0, 99) < 45);
        rd = DATA_W'($urandom);
        exp_head = (mq.size() > 0) ? mq[0] : rd;
        r = $urandom_range(0, 19);
        applyStimulus("rand", iv, rd, ov,
                      (r == 0) ? DATA_W'($urandom) : (exp_head ^ (DATA_W'($urandom) & ~MASK)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
    $finish;
  end

endmodule
